// File: rtl/bin_loader_pkg.sv
// Shared frame codes, masks and enums for the PDP-8 BIN paper-tape loader.
package bin_loader_pkg;
   localparam logic [7:0] LEADER     = 8'o200;
   localparam logic [7:0] RUBOUT     = 8'o377;
   localparam logic [7:0] FIELD_MASK = 8'o307;
   localparam logic [7:0] FIELD_CODE = 8'o300;
   localparam logic [7:0] ORG_MASK   = 8'o300;
   localparam logic [7:0] ORG_CODE   = 8'o100;
   localparam logic [7:0] DATA_CODE  = 8'o000;

   typedef enum logic [2:0] {ST_IDLE, ST_LEADER, ST_HI, ST_LO, ST_DONE} state_e;
   typedef enum logic [2:0] {CL_LEAD, CL_RUB, CL_FIELD, CL_ORG_HI, CL_DATA, CL_BAD} frame_cls_e;
endpackage

// File: rtl/bin_frame_classify.sv
// Combinational BIN frame decoder; field value is only decoded when BIN_FIELD_EN is defined.
module bin_frame_classify
   import bin_loader_pkg::*;
(
   input  logic [0:7]  rx_data,
   output frame_cls_e  o_cls,
   output logic [0:2]  o_field
);
   always_comb begin
      o_cls = CL_BAD;
      if (rx_data == RUBOUT)                          o_cls = CL_RUB;
      else if (rx_data == LEADER)                     o_cls = CL_LEAD;
      else if ((rx_data & FIELD_MASK) == FIELD_CODE)  o_cls = CL_FIELD;
      else if ((rx_data & ORG_MASK) == ORG_CODE)      o_cls = CL_ORG_HI;
      else if ((rx_data & ORG_MASK) == DATA_CODE)     o_cls = CL_DATA;
   end

`ifdef BIN_FIELD_EN
   assign o_field = rx_data[2:4];
`else
   assign o_field = 3'b000;
`endif
endmodule

// File: rtl/bin_tape_loader.sv
// PDP-8 BIN tape loader: leader detect, word assembly, one-word lookahead, checksum.
// Define BIN_FIELD_EN to let field frames drive mem_field.
module bin_tape_loader
   import bin_loader_pkg::*;
#(
   parameter int LEADER_MIN = 8,
   parameter int ADDR_W     = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [0:7]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [0:ADDR_W-1] mem_addr,
   output logic [0:11]       mem_data,
   output logic [0:2]        mem_field,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic              cksum_ok,
   output logic              cksum_err,
   output logic              fmt_err
);
   localparam int CNT_W = $clog2(LEADER_MIN + 1);

   frame_cls_e w_cls;
   logic [0:2] w_fld;
   logic       w_acc;
   logic       w_hi_frame;

   state_e            r_state;
   logic [CNT_W-1:0]  r_lcnt;
   logic              r_ign;
   logic [0:7]        r_hi;
   logic              r_pend_vld;
   logic              r_pend_org;
   logic [0:7]        r_pend_hi;
   logic [0:7]        r_pend_lo;
   logic [0:11]       r_pend_val;
   logic [0:ADDR_W-1] r_addr;
   logic [0:11]       r_sum;
   logic              r_rdy;
   logic [0:ADDR_W-1] r_mem_addr;
   logic [0:11]       r_mem_data;
   logic              r_we, r_busy, r_done, r_ok, r_err, r_fmt;
`ifdef BIN_FIELD_EN
   logic [0:2]        r_field;
`endif

   bin_frame_classify u_cls (
      .rx_data (rx_data),
      .o_cls   (w_cls),
      .o_field (w_fld)
   );

   assign w_acc      = rx_valid & r_rdy;
   assign w_hi_frame = (w_cls == CL_ORG_HI) || (w_cls == CL_DATA);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_lcnt     <= '0;
         r_ign      <= 1'b0;
         r_hi       <= '0;
         r_pend_vld <= 1'b0;
         r_pend_org <= 1'b0;
         r_pend_hi  <= '0;
         r_pend_lo  <= '0;
         r_pend_val <= '0;
         r_addr     <= '0;
         r_sum      <= '0;
         r_rdy      <= 1'b0;
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_we       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ok       <= 1'b0;
         r_err      <= 1'b0;
         r_fmt      <= 1'b0;
`ifdef BIN_FIELD_EN
         r_field    <= '0;
`endif
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         r_rdy  <= 1'b1;
         if (r_state == ST_DONE) begin
            r_state <= ST_IDLE;
            r_lcnt  <= '0;
         end else if (w_acc) begin
            if (w_cls == CL_RUB) begin
               r_ign <= ~r_ign;
            end else if (!r_ign) begin
`ifdef BIN_FIELD_EN
               if (w_cls == CL_FIELD) r_field <= w_fld;
`endif
               if (w_cls == CL_BAD) r_fmt <= 1'b1;
               case (r_state)
                  ST_IDLE: begin
                     if (w_cls != CL_LEAD) begin
                        r_lcnt <= '0;
                     end else if (r_lcnt == CNT_W'(LEADER_MIN - 1)) begin
                        r_state    <= ST_LEADER;
                        r_lcnt     <= '0;
                        r_busy     <= 1'b1;
                        r_ok       <= 1'b0;
                        r_err      <= 1'b0;
                        r_fmt      <= 1'b0;
                        r_sum      <= '0;
                        r_pend_vld <= 1'b0;
                     end else begin
                        r_lcnt <= r_lcnt + CNT_W'(1);
                     end
                  end
                  ST_LEADER, ST_HI: begin
                     if (w_hi_frame) begin
                        r_hi    <= rx_data;
                        r_state <= ST_LO;
                     end else if (w_cls == CL_LEAD && r_state == ST_HI) begin
                        // Trailer: the held-back word is the checksum and is never written.
                        r_state    <= ST_DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_rdy      <= 1'b0;
                        r_pend_vld <= 1'b0;
                        if (r_pend_vld && !r_pend_org) begin
                           if (r_pend_val == r_sum) r_ok  <= 1'b1;
                           else                     r_err <= 1'b1;
                        end else begin
                           r_fmt <= 1'b1;
                        end
                     end
                  end
                  ST_LO: begin
                     if (w_cls == CL_DATA) begin
                        if (r_pend_vld) begin
                           r_sum <= r_sum + {4'b0000, r_pend_hi} + {4'b0000, r_pend_lo};
                           if (r_pend_org) begin
                              r_addr <= r_pend_val;
                           end else begin
                              r_we       <= 1'b1;
                              r_mem_addr <= r_addr;
                              r_mem_data <= r_pend_val;
                              r_addr     <= r_addr + ADDR_W'(1);
                           end
                        end
                        r_pend_vld <= 1'b1;
                        r_pend_org <= r_hi[1];
                        r_pend_hi  <= r_hi;
                        r_pend_lo  <= rx_data;
                        r_pend_val <= {r_hi[2:7], rx_data[2:7]};
                        r_state    <= ST_HI;
                     end else if (w_cls == CL_LEAD || w_cls == CL_ORG_HI) begin
                        r_fmt   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_lcnt  <= '0;
                        r_state <= ST_IDLE;
                     end
                  end
                  default: r_state <= ST_IDLE;
               endcase
            end
         end
      end
   end

   assign rx_ready  = r_rdy;
   assign mem_addr  = r_mem_addr;
   assign mem_data  = r_mem_data;
   assign mem_we    = r_we;
   assign busy      = r_busy;
   assign done      = r_done;
   assign cksum_ok  = r_ok;
   assign cksum_err = r_err;
   assign fmt_err   = r_fmt;
`ifdef BIN_FIELD_EN
   assign mem_field = r_field;
`else
   assign mem_field = w_fld;
`endif
endmodule

// File: tb/tb_bin_tape_loader.sv
// Scoreboard bench for bin_tape_loader: expected writes queued by stimulus, checked by a monitor.
module tb_bin_tape_loader;
   typedef struct {
      logic [11:0] a;
      logic [11:0] d;
      logic [2:0]  f;
   } wr_t;

`ifdef BIN_FIELD_EN
   localparam logic [2:0] FLD2 = 3'd2;
`else
   localparam logic [2:0] FLD2 = 3'd0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [11:0] mem_addr;
   logic [11:0] mem_data;
   logic [2:0]  mem_field;
   logic        mem_we, busy, done, cksum_ok, cksum_err, fmt_err;

   int  n_chk  = 0;
   int  n_fail = 0;
   int  n_done = 0;
   wr_t exp_q[$];
   wr_t mon_e;

   always #5 clk = ~clk;

   bin_tape_loader #(.LEADER_MIN(8), .ADDR_W(12)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_field (mem_field),
      .mem_we    (mem_we),
      .busy      (busy),
      .done      (done),
      .cksum_ok  (cksum_ok),
      .cksum_err (cksum_err),
      .fmt_err   (fmt_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      if (done) n_done++;
      if (mem_we) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %03h data %03h, expected no write", mem_addr, mem_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", {20'd0, mem_addr}, {20'd0, mon_e.a});
            chk("wr_data", {20'd0, mem_data}, {20'd0, mon_e.d});
            chk("wr_field", {29'd0, mem_field}, {29'd0, mon_e.f});
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) chk("rx_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic leader();
      for (int i = 0; i < 8; i++) send(8'o200);
   endtask

   task automatic push_wr(input logic [11:0] a, input logic [11:0] d, input logic [2:0] f);
      wr_t w;
      w.a = a; w.d = d; w.f = f;
      exp_q.push_back(w);
   endtask

   task automatic tape_end(input string nm, input logic ok, input logic err, input logic fmt,
                           input int ndone);
      repeat (3) @(negedge clk);
      chk({nm, "_cksum_ok"},  {31'd0, cksum_ok},  {31'd0, ok});
      chk({nm, "_cksum_err"}, {31'd0, cksum_err}, {31'd0, err});
      chk({nm, "_fmt_err"},   {31'd0, fmt_err},   {31'd0, fmt});
      chk({nm, "_busy"},      {31'd0, busy},      32'd0);
      chk({nm, "_done_cnt"},  n_done,             ndone);
      chk({nm, "_writes_left"}, exp_q.size(),     32'd0);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
      chk({nm, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
      chk({nm, "_mem_data"}, {20'd0, mem_data}, 32'd0);
      chk({nm, "_mem_we"},   {31'd0, mem_we},   32'd0);
      chk({nm, "_flags"},    {26'd0, busy, done, cksum_ok, cksum_err, fmt_err, 1'b0}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      chk("reset_field", {29'd0, mem_field}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("rdy_after_reset", {31'd0, rx_ready}, 32'd1);

      // Basic load: origin 0100, data 0x4B4, checksum 0x087
      n_done = 0;
      push_wr(12'h040, 12'h4B4, 3'd0);
      leader();
      @(negedge clk);
      chk("armed_busy", {31'd0, busy}, 32'd1);
      send(8'h41); send(8'h00); send(8'h12); send(8'h34);
      send(8'h02); send(8'h07); send(8'o200);
      tape_end("basic", 1'b1, 1'b0, 1'b0, 1);

      // Bad checksum
      n_done = 0;
      push_wr(12'h040, 12'h4B4, 3'd0);
      leader();
      send(8'h41); send(8'h00); send(8'h12); send(8'h34);
      send(8'h02); send(8'h08); send(8'o200);
      tape_end("badsum", 1'b0, 1'b1, 1'b0, 1);

      // Address wrap 07777 -> 0
      n_done = 0;
      push_wr(12'hFFF, 12'h111, 3'd0);
      push_wr(12'h000, 12'h222, 3'd0);
      leader();
      send(8'h7F); send(8'h3F); send(8'h04); send(8'h11);
      send(8'h08); send(8'h22); send(8'h03); send(8'h3D); send(8'o200);
      tape_end("wrap", 1'b1, 1'b0, 1'b0, 1);

      // Rubout bracket hides 0x55
      n_done = 0;
      push_wr(12'h040, 12'h4B4, 3'd0);
      leader();
      send(8'h41); send(8'h00);
      send(8'o377); send(8'h55); send(8'o377);
      send(8'h12); send(8'h34); send(8'h02); send(8'h07); send(8'o200);
      tape_end("rubout", 1'b1, 1'b0, 1'b0, 1);

      // Leader frame where a low frame belongs
      n_done = 0;
      leader();
      send(8'h41); send(8'o200);
      tape_end("fmt", 1'b0, 1'b0, 1'b1, 0);

      // Reset mid-word: pending data word must never be written
      leader();
      send(8'h41); send(8'h00); send(8'h12); send(8'h34); send(8'h02);
      chk("mid_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_no_write", exp_q.size(), 32'd0);

      // Field frame 0320 ahead of origin
      n_done = 0;
      push_wr(12'h040, 12'h4B4, FLD2);
      leader();
      send(8'o320);
      send(8'h41); send(8'h00); send(8'h12); send(8'h34);
      send(8'h02); send(8'h07); send(8'o200);
      tape_end("field", 1'b1, 1'b0, 1'b0, 1);
      chk("field_persist", {29'd0, mem_field}, {29'd0, FLD2});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
